// File: rtl/neuron_pkg.sv
// Shared types and width/limit helpers for the neuron pre-activation sequencer.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  // Accumulator needs CW guard bits so K_MAX terms of N-bit products cannot overflow.
  function automatic int accWidth(input int n, input int cw);
    return n + cw;
  endfunction

  function automatic int satMax(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int satMin(input int n);
    return -(1 << (n - 1));
  endfunction

endpackage

// File: rtl/neuron_mac_seq_sat_acc.sv
// Signed accumulator with load/add and a saturated N-bit view of its next value.
module sat_acc
  import neuron_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                add,
  input  logic signed [N-1:0] loadVal,
  input  logic signed [N-1:0] addVal,
  output logic signed [N-1:0] satNext
);

  localparam int ACC_W = accWidth(N, CW);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(satMax(N));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(satMin(N));
  localparam logic signed [N-1:0]     Y_MAX   = N'(satMax(N));
  localparam logic signed [N-1:0]     Y_MIN   = N'(satMin(N));

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] accNext;

  // Saturation looks at the next value so the result can be captured on the
  // same edge that folds in the final term.
  always_comb begin
    accNext = acc;
    if (load) begin
      accNext = {{CW{loadVal[N-1]}}, loadVal};
    end else if (add) begin
      accNext = acc + {{CW{addVal[N-1]}}, addVal};
    end
    if (accNext > ACC_MAX) begin
      satNext = Y_MAX;
    end else if (accNext < ACC_MIN) begin
      satNext = Y_MIN;
    end else begin
      satNext = accNext[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= accNext;
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Streams X/W pairs through a shared multiplier, accumulates onto a bias and
// returns a saturated result. Y is offered with Y_VALID and retires on the
// edge where Y_VALID and Y_READY are both high; Y/Y_VALID hold until then.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int N     = 8,
  parameter int K_MAX = 16,
  parameter int CW    = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [CW-1:0] LEN,
  input  logic [N-1:0]  BIAS,
  output logic [CW-1:0] ADDR,
  input  logic [N-1:0]  X_DATA,
  input  logic [N-1:0]  W_DATA,
  output logic [N-1:0]  MPY_A,
  output logic [N-1:0]  MPY_B,
  input  logic [N-1:0]  MPY_P,
  output logic          BUSY,
  output logic [N-1:0]  Y,
  output logic          Y_VALID,
  input  logic          Y_READY,
  output state_t        dbgState
);

  state_t        state, nextState;
  logic [CW-1:0] idx, lastAddr, lenReg, lenClamped;
  logic          pipe;
  logic          accLoad;
  logic [N-1:0]  yReg;
  logic [N-1:0]  satNext;

  assign lenClamped = (LEN > CW'(K_MAX)) ? CW'(K_MAX) : LEN;

  always_comb begin
    nextState = state;
    accLoad   = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accLoad   = 1'b1;
          nextState = (LEN == '0) ? OUT : RUN;
        end
      end
      RUN:     if (idx == lenReg - CW'(1)) nextState = DRAIN;
      DRAIN:   nextState = OUT;
      OUT:     if (Y_READY) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      lastAddr <= '0;
      lenReg   <= '0;
      pipe     <= 1'b0;
      yReg     <= '0;
    end else begin
      state <= nextState;
      pipe  <= (state == RUN);
      if (state == IDLE && START) begin
        idx    <= '0;
        lenReg <= lenClamped;
      end
      if (state == RUN) begin
        lastAddr <= idx;
        idx      <= idx + CW'(1);
      end
      if (nextState == OUT && state != OUT) yReg <= satNext;
    end
  end

  // Memory reads are issued combinationally in RUN; data lands while pipe is set.
  assign ADDR     = (state == RUN) ? idx : lastAddr;
  assign MPY_A    = pipe ? X_DATA : '0;
  assign MPY_B    = pipe ? W_DATA : '0;
  assign BUSY     = (state != IDLE);
  assign Y_VALID  = (state == OUT);
  assign Y        = yReg;
  assign dbgState = state;

  sat_acc #(.N(N), .CW(CW)) uAcc (
    .clk     (CLK),
    .rst     (RST),
    .load    (accLoad),
    .add     (pipe),
    .loadVal (BIAS),
    .addVal  (MPY_P),
    .satNext (satNext)
  );

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with a sum-of-products reference model.
module tb_neuron_mac_seq;
  localparam int N     = 8;
  localparam int K_MAX = 16;
  localparam int CW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CW-1:0]       len;
  logic [N-1:0]        bias;
  logic [CW-1:0]       addr;
  logic [N-1:0]        x_data, w_data;
  logic [N-1:0]        mpy_a, mpy_b, mpy_p;
  logic                busy;
  logic [N-1:0]        y;
  logic                y_valid;
  logic                y_ready;
  neuron_pkg::state_t  dbg_state;

  logic [N-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [N-1:0] x_mem[32];
  logic [N-1:0] w_mem[32];

  neuron_mac_seq #(.N(N), .K_MAX(K_MAX), .CW(CW)) dut (
    .CLK(clk), .RST(rst), .START(start), .LEN(len), .BIAS(bias),
    .ADDR(addr), .X_DATA(x_data), .W_DATA(w_data),
    .MPY_A(mpy_a), .MPY_B(mpy_b), .MPY_P(mpy_p),
    .BUSY(busy), .Y(y), .Y_VALID(y_valid), .Y_READY(y_ready),
    .dbgState(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous memories: data valid one cycle after ADDR
  always @(posedge clk) begin
    x_data <= x_mem[addr];
    w_data <= w_mem[addr];
  end

  // sign-magnitude multiplier: |a|*|b| mod 2^(N-1), sign = xor of signs
  function automatic logic [N-1:0] mul_model(input logic [N-1:0] a, input logic [N-1:0] b);
    int ma, mb, pm;
    ma = a[N-1] ? (256 - int'(a)) : int'(a);
    mb = b[N-1] ? (256 - int'(b)) : int'(b);
    pm = ((ma % 128) * (mb % 128)) % 128;
    if (a[N-1] ^ b[N-1]) pm = -pm;
    return pm[N-1:0];
  endfunction

  assign mpy_p = mul_model(mpy_a, mpy_b);

  function automatic logic [N-1:0] model_y(input int n_terms, input int b);
    int acc, l;
    logic signed [N-1:0] p;
    l = (n_terms > K_MAX) ? K_MAX : n_terms;
    acc = b;
    for (int i = 0; i < l; i++) begin
      p = mul_model(x_mem[i], w_mem[i]);
      acc += int'(p);
    end
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return acc[N-1:0];
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, required);
    end
  endtask

  // scoreboard compare: every cycle Y is offered it must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && y_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("y_vs_model", int'(y), int'(exp_q[0]));
    end
  end

  always @(posedge clk) begin
    if (!rst && y_valid && y_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = 8'd50;
      w_mem[i] = 8'd50;
    end
  endtask

  task automatic set_term(input int i, input int xv, input int wv);
    x_mem[i] = xv[N-1:0];
    w_mem[i] = wv[N-1:0];
  endtask

  task automatic run_job(input int n, input int b, input logic [N-1:0] lit, input string name);
    int lat, l;
    l = (n > K_MAX) ? K_MAX : n;
    exp_q.push_back(model_y(n, b));
    start = 1'b1;
    len   = n[CW-1:0];
    bias  = b[N-1:0];
    tick();
    start = 1'b0;
    lat = 0;
    while (!y_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, (l == 0) ? 0 : l + 1);
    check({name, "_y"}, int'(y), int'(lit));
    tick();
    check({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic load_basic();
    clear_mem();
    set_term(0, 10, 3);
    set_term(1, -4, 6);
    set_term(2, 7, -2);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; len = '0; bias = '0; y_ready = 1'b1;
    clear_mem();
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_mpy_a", int'(mpy_a), 0);
    check("rst_mpy_b", int'(mpy_b), 0);
    check("rst_y", int'(y), 0);
    check("rst_y_valid", int'(y_valid), 0);
    rst = 1'b0;
    tick();

    load_basic();
    run_job(3, 5, 8'hFD, "basic");

    clear_mem();
    for (int i = 0; i < 4; i++) set_term(i, 11, 11);
    run_job(4, 0, 8'h7F, "pos_sat");

    clear_mem();
    for (int i = 0; i < 4; i++) set_term(i, 11, -11);
    set_term(4, -128, 3);
    run_job(5, -10, 8'h80, "neg_sat");

    run_job(0, -7, 8'hF9, "zero_len");
    check("zero_len_addr", int'(addr), 4);

    clear_mem();
    for (int i = 0; i < 16; i++) set_term(i, 1, 1);
    run_job(20, 0, 8'd16, "clamp");

    // backpressure with START pulsing while Y is held
    clear_mem();
    set_term(0, 5, 4);
    set_term(1, -3, 9);
    y_ready = 1'b0;
    exp_q.push_back(model_y(2, 20));
    start = 1'b1; len = 5'd2; bias = 8'd20;
    tick();
    start = 1'b0;
    lat = 0;
    while (!y_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 3);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; len = 5'd1; bias = 8'd99;
      tick();
      check("bp_y_hold", int'(y), 13);
      check("bp_valid_hold", int'(y_valid), 1);
    end
    y_ready = 1'b1;
    len = 5'd0;
    tick();
    start = 1'b0;
    check("bp_release_idle", int'(busy), 0);
    check("bp_release_valid", int'(y_valid), 0);
    load_basic();
    run_job(3, 5, 8'hFD, "after_bp");

    // reset in the middle of RUN
    clear_mem();
    start = 1'b1; len = 5'd8; bias = 8'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_rst_addr", int'(addr), 2);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(y_valid), 0);
    rst = 1'b0;
    tick();
    load_basic();
    run_job(3, 5, 8'hFD, "rerun");

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
